vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Generates 640x480@60Hz VGA raster timing from the board clock.
//  Drives hSync/vSync to the connector, and drives hCount/vCount/bright to pixel-consumer blocks.
//  Consumers return 12-bit rgb for the current hCount/vCount.
//  Also produces a once-per-frame strobe so game logic can update object positions during vertical blanking.
// PARAMETERS
//  CLK_DIV    4    clk cycles per pixel (100 MHz -> 25 MHz pixel rate)
//  H_SYNC     96   hCount < H_SYNC   => hSync active (low)
//  H_BP_END   144  first visible column
//  H_ACT_END  784  first non-visible column after active area
//  H_TOTAL    800  columns per line; hCount range 0..H_TOTAL-1
//  V_SYNC     2    vCount < V_SYNC   => vSync active (low)
//  V_BP_END   35   first visible line
//  V_ACT_END  515  first non-visible line after active area
//  V_TOTAL    525  lines per frame; vCount range 0..V_TOTAL-1
// PORTS
//  clk          in   1   system clock, 100 MHz; all logic on posedge
//  rst          in   1   synchronous, active-high reset
//  pix_en       out  1   one-clk pulse every CLK_DIV clks; counters advance on it
//  hCount       out  10  current column
//  vCount       out  10  current line
//  hSync        out  1   horizontal sync, active low
//  vSync        out  1   vertical sync, active low
//  bright       out  1   1 when (hCount,vCount) is inside the active 640x480 window
//  frame_tick   out  1   one-clk pulse at start of vertical blanking
//  frame_count  out  8   frames completed, increments on frame_tick
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - div=0, hCount=0, vCount=0, frame_count=0.
//   - hSync=0, vSync=0, bright=0, frame_tick=0, pix_en=0.
//   - rst dominates pix_en and any in-progress line/frame; the next edge returns everything to these values.
//  Divider:
//   - div counts 0..CLK_DIV-1 and wraps.
//   - pix_en = (div==CLK_DIV-1), decoded from the register.
//   - First pix_en is in the 4th clk after rst deasserts.
//  Counters, updated only on edges where pix_en=1:
//   - hCount==H_TOTAL-1 -> hCount=0, and vCount advances; otherwise hCount+1.
//   - vCount==V_TOTAL-1 at end of line -> vCount=0; otherwise vCount+1.
//   - Wrap (799,524) -> (0,0) is seamless; no idle pixel.
//  Sync/bright:
//   - Registered, computed from the next counter values.
//   - They are valid in the same cycle as the hCount/vCount they describe; zero skew to consumers.
//   - hSync  = ~(h < H_SYNC); vSync = ~(v < V_SYNC).
//   - bright = (H_BP_END <= h < H_ACT_END) && (V_BP_END <= v < V_ACT_END).
//  Frame tick:
//   - frame_tick=1 for exactly one clk, on the pix_en edge where hCount==H_TOTAL-1 && vCount==V_ACT_END-1.
//   - frame_count += 1 on that same edge, wrapping at 8 bits (255 -> 0).
//  Invariants:
//   - Outputs are stable between pix_en pulses.
//   - bright is never 1 while hSync=0 or vSync=0.
//   - Exactly one frame_tick per V_TOTAL*H_TOTAL*CLK_DIV clks (1,680,000).
//  Widths: 10-bit counters cover 0..1023; compares are unsigned; no overflow paths.
// STRUCTURE
//  vga_timing_pkg holds:
//   - timing constants (H_*, V_*, CLK_DIV defaults);
//   - shared 12-bit colour constants (RED, WHITE, PINK, BLUE, BLACK, PURPLE, BRIGHT_GREEN);
//   - screen-space wall/ceiling/floor limits used by pixel consumers.
//  One sub-module: pixel_enable_div (param DIV; ports clk, rst, en), reused by other clock-enable users.
//  Counters, sync/bright decode and frame-tick logic stay in this module.
// TESTING
//  1. rst held 3 clks, then released:
//     - all outputs at reset values;
//     - first pix_en in clk 4;
//     - hCount=1 on the following clk.
//  2. Run one line:
//     - hSync low for hCount 0..95, high 96..799;
//     - hCount wraps 799->0 and vCount 0->1 on the same pix_en edge.
//  3. Run one full frame:
//     - bright high exactly 640*480=307200 pixels;
//     - first bright at (144,35), last at (783,514);
//     - vSync low only on lines 0..1.
//  4. Frame strobe:
//     - frame_tick single-clk pulse at (799,514);
//     - spacing exactly 1,680,000 clks;
//     - frame_count 255 -> 0 after 256 frames (force via reset-to-253 backdoor).
//  5. Assert rst at (400,300) mid-frame:
//     - next edge gives hCount=0, vCount=0, div=0, frame_count=0;
//     - no frame_tick emitted.
//  6. Continuous assertions over 3 frames:
//     - bright implies hSync&vSync;
//     - counts never exceed 799/524;
//     - outputs change only on pix_en edges.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA definitions: 640x480@60Hz timing defaults, 12-bit colours and
// the screen-space playfield limits used by pixel consumers.
package vga_timing_pkg;

   // Raster timing defaults (pixel clock derived from a 100 MHz board clock)
   localparam int unsigned CLK_DIV_DEF   = 4;
   localparam int unsigned H_SYNC_DEF    = 96;
   localparam int unsigned H_BP_END_DEF  = 144;
   localparam int unsigned H_ACT_END_DEF = 784;
   localparam int unsigned H_TOTAL_DEF   = 800;
   localparam int unsigned V_SYNC_DEF    = 2;
   localparam int unsigned V_BP_END_DEF  = 35;
   localparam int unsigned V_ACT_END_DEF = 515;
   localparam int unsigned V_TOTAL_DEF   = 525;

   // 12-bit RGB (4:4:4) colour constants
   localparam logic [11:0] RED          = 12'hF00;
   localparam logic [11:0] WHITE        = 12'hFFF;
   localparam logic [11:0] PINK         = 12'hF6B;
   localparam logic [11:0] BLUE         = 12'h00F;
   localparam logic [11:0] BLACK        = 12'h000;
   localparam logic [11:0] PURPLE       = 12'h80F;
   localparam logic [11:0] BRIGHT_GREEN = 12'h0F0;

   // Playfield limits in raster coordinates (inside the visible window)
   localparam logic [9:0] WALL_LEFT  = 10'd164;
   localparam logic [9:0] WALL_RIGHT = 10'd763;
   localparam logic [9:0] CEILING    = 10'd55;
   localparam logic [9:0] FLOOR      = 10'd494;

   // Half-open interval test: lo <= pos < hi
   function automatic logic in_span(input logic [9:0] pos,
                                    input logic [9:0] lo,
                                    input logic [9:0] hi);
      return (pos >= lo) && (pos < hi);
   endfunction

endpackage

// File: rtl/pixel_enable_div.sv
// Clock-enable generator: one-clk pulse every DIV clocks, decoded from the
// divider register so the pulse is glitch-free and aligned to the clock.
module pixel_enable_div
   import vga_timing_pkg::*;
#(
   parameter int unsigned DIV = CLK_DIV_DEF
) (
   input  logic clk,
   input  logic rst,
   output logic en
);

   localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [W-1:0] div;

   // Modulo-DIV counter; restarts from zero on reset
   always_ff @(posedge clk) begin
      if (rst)
         div <= '0;
      else if (div == W'(DIV - 1))
         div <= '0;
      else
         div <= div + W'(1);
   end

   assign en = (div == W'(DIV - 1));

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: column/line counters advanced on the pixel
// enable, registered sync/bright aligned with the counters, and a frame
// strobe at the start of vertical blanking.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned CLK_DIV   = CLK_DIV_DEF,
   parameter int unsigned H_SYNC    = H_SYNC_DEF,
   parameter int unsigned H_BP_END  = H_BP_END_DEF,
   parameter int unsigned H_ACT_END = H_ACT_END_DEF,
   parameter int unsigned H_TOTAL   = H_TOTAL_DEF,
   parameter int unsigned V_SYNC    = V_SYNC_DEF,
   parameter int unsigned V_BP_END  = V_BP_END_DEF,
   parameter int unsigned V_ACT_END = V_ACT_END_DEF,
   parameter int unsigned V_TOTAL   = V_TOTAL_DEF
) (
   input  logic       clk,
   input  logic       rst,
   output logic       pix_en,
   output logic [9:0] hCount,
   output logic [9:0] vCount,
   output logic       hSync,
   output logic       vSync,
   output logic       bright,
   output logic       frame_tick,
   output logic [7:0] frame_count
);

   localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_ACT_LST = 10'(V_ACT_END - 1);

   logic [9:0] h_next;
   logic [9:0] v_next;
   logic       line_end;
   logic       blank_start;

   pixel_enable_div #(.DIV(CLK_DIV)) u_pix_div (
      .clk (clk),
      .rst (rst),
      .en  (pix_en)
   );

   // Next raster position; wrap (last col, last line) -> (0,0) with no idle pixel
   always_comb begin
      line_end    = (hCount == H_LAST);
      h_next      = line_end ? 10'd0 : hCount + 10'd1;
      v_next      = vCount;
      if (line_end)
         v_next = (vCount == V_LAST) ? 10'd0 : vCount + 10'd1;
      blank_start = line_end && (vCount == V_ACT_LST);
   end

   // Counters plus sync/bright decoded from the next position so all move together
   always_ff @(posedge clk) begin
      if (rst) begin
         hCount      <= '0;
         vCount      <= '0;
         hSync       <= 1'b0;
         vSync       <= 1'b0;
         bright      <= 1'b0;
         frame_tick  <= 1'b0;
         frame_count <= '0;
      end else begin
         frame_tick <= 1'b0;
         if (pix_en) begin
            hCount <= h_next;
            vCount <= v_next;
            hSync  <= !(h_next < 10'(H_SYNC));
            vSync  <= !(v_next < 10'(V_SYNC));
            bright <= in_span(h_next, 10'(H_BP_END), 10'(H_ACT_END)) &&
                      in_span(v_next, 10'(V_BP_END), 10'(V_ACT_END));
            if (blank_start) begin
               frame_tick  <= 1'b1;
               frame_count <= frame_count + 8'd1;
            end
         end
      end
   end

endmodule
